mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage controller sitting directly upstream of the data memory in the pipelined processor. It turns EX/MEM operations (load, store, push, pop, call, return) into `dataMemory` read/write strobes and addresses. It owns the stack pointer and sequences 32-bit PC save/restore as two 16-bit accesses, stalling the pipeline for the extra cycle. Load/pop/return results are registered for the MEM/WB stage.

## Interface
Parameters:
- ADDR_W, 10, memory address width; SP range 0 .. 2^ADDR_W-1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  op fields valid this cycle
- op  in  3  0 NOP, 1 LDD, 2 STD, 3 PUSH, 4 POP, 5 CALL, 6 RET; 7 treated as NOP
- addr_in  in  16  effective address for LDD/STD; low ADDR_W bits used
- data_in  in  16  store/push data
- pc_in  in  32  return address saved by CALL
- mem_read_enable  out  1  to data memory
- mem_write_enable  out  1  to data memory
- mem_read_addr  out  ADDR_W  to data memory
- mem_write_addr  out  ADDR_W  to data memory
- mem_write_data  out  16  to data memory
- mem_read_data  in  16  from data memory; valid before the next posedge
- stall  out  1  upstream must hold op/addr_in/data_in/pc_in stable
- result_valid  out  1  registered; result_data is valid
- result_data  out  16  registered LDD/POP data
- pc_out_valid  out  1  registered; pc_out is valid
- pc_out  out  32  registered RET target
- sp  out  ADDR_W  current stack pointer

## Operation
- State machine: IDLE, CALL2, RET2.
- Memory strobes and addresses are combinational from state, op and SP. Unused address/data outputs drive 0. Strobes are 0 when op_valid=0.
- SP is a full-descending stack. It resets to 2^ADDR_W-1. All SP arithmetic is modulo 2^ADDR_W, so it wraps silently with no over/underflow flag.
- IDLE behaviour per op:
  - LDD: read at addr_in. Next cycle result_valid=1, result_data=mem_read_data.
  - STD: write data_in at addr_in.
  - PUSH: write data_in at SP, then SP←SP-1.
  - POP: read at SP+1, then SP←SP+1. Next cycle result_valid=1.
  - CALL: write pc_in[31:16] at SP, stall=1, go to CALL2.
  - RET: read at SP+1, latch mem_read_data into the low-half holding reg, stall=1, go to RET2.
- CALL2: write pc_in[15:0] at SP-1, SP←SP-2, stall=0, go to IDLE.
- RET2: read at SP+2. pc_out←{mem_read_data, low-half holding reg}, SP←SP+2, stall=0, go to IDLE. Next cycle pc_out_valid=1.
- Stack memory order: CALL stores the high half at the higher address; RET reads the low half first (SP+1), then the high half (SP+2).
- result_valid and pc_out_valid are single-cycle pulses. result_data and pc_out hold their value until next overwritten.
- Read and write enables are never both asserted in one cycle.

## Timing
- Reset values: sp=2^ADDR_W-1, state IDLE, stall=0, result_valid=0, result_data=0, pc_out_valid=0, pc_out=0, holding reg=0.
- During rst=1, all mem strobes are 0.
- Latency:
  - LDD/POP: result 1 cycle after issue.
  - RET: 2-cycle occupancy; pc_out_valid in the cycle after RET2.
  - CALL: 2-cycle occupancy.
  - STD/PUSH: single cycle, no stall.
- stall is combinational and high only in the first cycle of CALL/RET. The op is consumed on the posedge where stall=0.
- Inputs in CALL2/RET2 are the held originals. op_valid dropping in CALL2/RET2 is illegal and is not checked.
- Back-to-back ops are allowed every cycle. POP immediately after PUSH returns the pushed value, because the memory write lands at posedge before the negedge read.
- Reset mid-CALL or mid-RET: return to IDLE, restore SP, suppress any pending valid pulse. A half-written CALL frame is left in memory.
- Wrap-around: SP=0 followed by PUSH gives SP=2^ADDR_W-1. CALL at SP=0 writes addresses 0 and 2^ADDR_W-1, and SP becomes 2^ADDR_W-2.

## Test plan
- Reset, then PUSH 0xAAAA, PUSH 0x5555, POP, POP -> writes at 0x3FF then 0x3FE; result_data 0x5555 then 0xAAAA; sp returns to 0x3FF.
- STD 0x1234 at addr_in 0x0010, then LDD 0x0010 -> result_valid pulse one cycle after LDD with 0x1234; addr_in 0xFC10 aliases to 0x010.
- CALL pc_in=0xDEADBEEF, then RET -> CALL stalls 1 cycle, writes 0xDEAD@0x3FF and 0xBEEF@0x3FE, sp=0x3FD; RET stalls 1 cycle, pc_out=0xDEADBEEF, sp=0x3FF.
- SP wrap: POP at reset SP -> reads 0x000, sp=0x000; then PUSH 0x0F0F -> write at 0x000, sp=0x3FF.
- rst asserted during CALL2 -> stall=0, sp=0x3FF, no write in the reset cycle, pc_out_valid never pulses.
- op=7 and op_valid=0 cycles -> no strobes, sp unchanged, no valid pulses.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage controller: turns LDD/STD/PUSH/POP/CALL/RET into data-memory strobes and owns SP; LDD/POP/RET results 1 cycle later.
// CALL/RET occupy two cycles as 16-bit halves; stall is high in their first cycle only, upstream holds inputs.
module mem_access_unit #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [15:0]       addr_in,
  input  logic [15:0]       data_in,
  input  logic [31:0]       pc_in,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [15:0]       mem_write_data,
  input  logic [15:0]       mem_read_data,
  output logic              stall,
  output logic              result_valid,
  output logic [15:0]       result_data,
  output logic              pc_out_valid,
  output logic [31:0]       pc_out,
  output logic [ADDR_W-1:0] sp
);

  localparam logic [2:0] OP_LDD  = 3'd1;
  localparam logic [2:0] OP_STD  = 3'd2;
  localparam logic [2:0] OP_PUSH = 3'd3;
  localparam logic [2:0] OP_POP  = 3'd4;
  localparam logic [2:0] OP_CALL = 3'd5;
  localparam logic [2:0] OP_RET  = 3'd6;

  typedef enum logic [1:0] {IDLE, CALL2, RET2} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   sp_q, sp_d;
  logic [15:0]         hold_q, hold_d;
  logic                result_valid_q, result_valid_d;
  logic [15:0]         result_data_q, result_data_d;
  logic                pc_out_valid_q, pc_out_valid_d;
  logic [31:0]         pc_out_q, pc_out_d;

  logic [ADDR_W-1:0]   addr_lo, sp_p1, sp_p2, sp_m1, sp_m2;
  logic                unused_addr_hi;

  // SP arithmetic wraps modulo 2^ADDR_W by construction of the width.
  assign addr_lo        = addr_in[ADDR_W-1:0];
  assign unused_addr_hi = ^addr_in[15:ADDR_W];
  assign sp_p1          = sp_q + ADDR_W'(1);
  assign sp_p2          = sp_q + ADDR_W'(2);
  assign sp_m1          = sp_q - ADDR_W'(1);
  assign sp_m2          = sp_q - ADDR_W'(2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      sp_q           <= '1;
      hold_q         <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      pc_out_valid_q <= 1'b0;
      pc_out_q       <= '0;
    end else begin
      state_q        <= state_d;
      sp_q           <= sp_d;
      hold_q         <= hold_d;
      result_valid_q <= result_valid_d;
      result_data_q  <= result_data_d;
      pc_out_valid_q <= pc_out_valid_d;
      pc_out_q       <= pc_out_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sp_d           = sp_q;
    hold_d         = hold_q;
    result_valid_d = 1'b0;
    result_data_d  = result_data_q;
    pc_out_valid_d = 1'b0;
    pc_out_d       = pc_out_q;
    if (op_valid) begin
      case (state_q)
        IDLE: begin
          case (op)
            OP_LDD: begin
              result_valid_d = 1'b1;
              result_data_d  = mem_read_data;
            end
            OP_PUSH: sp_d = sp_m1;
            OP_POP: begin
              sp_d           = sp_p1;
              result_valid_d = 1'b1;
              result_data_d  = mem_read_data;
            end
            OP_CALL: state_d = CALL2;
            OP_RET: begin
              hold_d  = mem_read_data;
              state_d = RET2;
            end
            default: ;
          endcase
        end
        CALL2: begin
          sp_d    = sp_m2;
          state_d = IDLE;
        end
        RET2: begin
          pc_out_d       = {mem_read_data, hold_q};
          pc_out_valid_d = 1'b1;
          sp_d           = sp_p2;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_read_addr    = '0;
    mem_write_addr   = '0;
    mem_write_data   = '0;
    stall            = 1'b0;
    if (!rst && op_valid) begin
      case (state_q)
        IDLE: begin
          case (op)
            OP_LDD: begin
              mem_read_enable = 1'b1;
              mem_read_addr   = addr_lo;
            end
            OP_STD: begin
              mem_write_enable = 1'b1;
              mem_write_addr   = addr_lo;
              mem_write_data   = data_in;
            end
            OP_PUSH: begin
              mem_write_enable = 1'b1;
              mem_write_addr   = sp_q;
              mem_write_data   = data_in;
            end
            OP_POP: begin
              mem_read_enable = 1'b1;
              mem_read_addr   = sp_p1;
            end
            OP_CALL: begin
              mem_write_enable = 1'b1;
              mem_write_addr   = sp_q;
              mem_write_data   = pc_in[31:16];
              stall            = 1'b1;
            end
            OP_RET: begin
              mem_read_enable = 1'b1;
              mem_read_addr   = sp_p1;
              stall           = 1'b1;
            end
            default: ;
          endcase
        end
        CALL2: begin
          mem_write_enable = 1'b1;
          mem_write_addr   = sp_m1;
          mem_write_data   = pc_in[15:0];
        end
        RET2: begin
          mem_read_enable = 1'b1;
          mem_read_addr   = sp_p2;
        end
        default: ;
      endcase
    end
  end

  assign result_valid = result_valid_q;
  assign result_data  = result_data_q;
  assign pc_out_valid = pc_out_valid_q;
  assign pc_out       = pc_out_q;
  assign sp           = sp_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: an op-level stack/memory model predicts every output each cycle.
module tb_mem_access_unit;

  localparam int AW = 10;

  localparam logic [2:0] NOP = 3'd0, LDD = 3'd1, STD = 3'd2, PUSH = 3'd3,
                         POP = 3'd4, CALL = 3'd5, RET = 3'd6, BAD = 3'd7;

  logic          clk = 1'b0;
  logic          rst, op_valid;
  logic [2:0]    op;
  logic [15:0]   addr_in, data_in;
  logic [31:0]   pc_in;
  logic          mem_read_enable, mem_write_enable;
  logic [AW-1:0] mem_read_addr, mem_write_addr;
  logic [15:0]   mem_write_data, mem_read_data;
  logic          stall, result_valid, pc_out_valid;
  logic [15:0]   result_data;
  logic [31:0]   pc_out;
  logic [AW-1:0] sp;

  int n_vec = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;
  logic mem_init = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .addr_in(addr_in),
    .data_in(data_in), .pc_in(pc_in), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_read_addr(mem_read_addr),
    .mem_write_addr(mem_write_addr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .stall(stall), .result_valid(result_valid),
    .result_data(result_data), .pc_out_valid(pc_out_valid), .pc_out(pc_out), .sp(sp)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 37) ^ 16'hC3A5;
  endfunction

  // Data memory driven by the DUT
  logic [15:0] dmem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < (1<<AW); i++) dmem[i] <= init_val(i);
    end else if (mem_write_enable) begin
      dmem[mem_write_addr] <= mem_write_data;
    end
  end
  assign mem_read_data = mem_read_enable ? dmem[mem_read_addr] : 16'h0;

  // Reference model: stack pointer, reference memory, pending registered results
  logic [15:0]   ref_mem [0:(1<<AW)-1];
  logic [AW-1:0] m_sp;
  int            m_phase;      // 0 free, 1 second half of CALL, 2 second half of RET
  logic          m_rv, m_pv;
  logic [15:0]   m_rd, m_hold;
  logic [31:0]   m_pc;

  logic          e_re, e_we, e_stall;
  logic [AW-1:0] e_ra, e_wa;
  logic [15:0]   e_wd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_expect();
    e_re = 0; e_we = 0; e_ra = '0; e_wa = '0; e_wd = '0; e_stall = 0;
    if (!rst && op_valid) begin
      if (m_phase == 1) begin
        e_we = 1; e_wa = m_sp - 10'd1; e_wd = pc_in[15:0];
      end else if (m_phase == 2) begin
        e_re = 1; e_ra = m_sp + 10'd2;
      end else begin
        case (op)
          LDD:  begin e_re = 1; e_ra = addr_in[AW-1:0]; end
          STD:  begin e_we = 1; e_wa = addr_in[AW-1:0]; e_wd = data_in; end
          PUSH: begin e_we = 1; e_wa = m_sp; e_wd = data_in; end
          POP:  begin e_re = 1; e_ra = m_sp + 10'd1; end
          CALL: begin e_we = 1; e_wa = m_sp; e_wd = pc_in[31:16]; e_stall = 1; end
          RET:  begin e_re = 1; e_ra = m_sp + 10'd1; e_stall = 1; end
          default: ;
        endcase
      end
    end
  endtask

  task automatic model_update();
    if (rst) begin
      m_sp = '1; m_phase = 0; m_rv = 0; m_pv = 0; m_rd = '0; m_hold = '0; m_pc = '0;
    end else begin
      m_rv = 0; m_pv = 0;
      if (op_valid) begin
        if (m_phase == 1) begin
          m_sp = m_sp - 10'd2; m_phase = 0;
        end else if (m_phase == 2) begin
          m_pc = {ref_mem[m_sp + 10'd2], m_hold}; m_pv = 1;
          m_sp = m_sp + 10'd2; m_phase = 0;
        end else begin
          case (op)
            LDD:  begin m_rv = 1; m_rd = ref_mem[addr_in[AW-1:0]]; end
            PUSH: m_sp = m_sp - 10'd1;
            POP:  begin m_rv = 1; m_rd = ref_mem[m_sp + 10'd1]; m_sp = m_sp + 10'd1; end
            CALL: m_phase = 1;
            RET:  begin m_hold = ref_mem[m_sp + 10'd1]; m_phase = 2; end
            default: ;
          endcase
        end
        if (e_we) ref_mem[e_wa] = e_wd;
      end
    end
  endtask

  // One cycle: drive inputs after the edge, predict, let the compare process look at negedge.
  task automatic cyc(input logic r, input logic v, input logic [2:0] o,
                     input logic [15:0] a, input logic [15:0] d, input logic [31:0] p);
    rst = r; op_valid = v; op = o; addr_in = a; data_in = d; pc_in = p;
    model_expect();
    @(posedge clk);
    model_update();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_read_enable",  32'(mem_read_enable),  32'(e_re));
      chk("mem_write_enable", 32'(mem_write_enable), 32'(e_we));
      chk("mem_read_addr",    32'(mem_read_addr),    32'(e_ra));
      chk("mem_write_addr",   32'(mem_write_addr),   32'(e_wa));
      chk("mem_write_data",   32'(mem_write_data),   32'(e_wd));
      chk("stall",            32'(stall),            32'(e_stall));
      chk("result_valid",     32'(result_valid),     32'(m_rv));
      chk("result_data",      32'(result_data),      32'(m_rd));
      chk("pc_out_valid",     32'(pc_out_valid),     32'(m_pv));
      chk("pc_out",           pc_out,                m_pc);
      chk("sp",               32'(sp),               32'(m_sp));
    end
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = init_val(i);
    m_sp = '1; m_phase = 0; m_rv = 0; m_pv = 0; m_rd = '0; m_hold = '0; m_pc = '0;
    mem_init = 1'b1;
    cyc(1, 0, NOP, 16'h0, 16'h0, 32'h0);
    mem_init = 1'b0;
    chk_en = 1'b1;
    cyc(1, 1, PUSH, 16'h0, 16'h1111, 32'h0);
    chk("lit_reset_sp", 32'(sp), 32'h3FF);
    chk("lit_reset_pc", pc_out, 32'h0);
    chk("lit_reset_rd", 32'(result_data), 32'h0);

    // push/pop ordering
    cyc(0, 1, PUSH, 16'h0, 16'hAAAA, 32'h0);
    cyc(0, 1, PUSH, 16'h0, 16'h5555, 32'h0);
    cyc(0, 1, POP,  16'h0, 16'h0,    32'h0);
    chk("lit_pop1", 32'(result_data), 32'h5555);
    cyc(0, 1, POP,  16'h0, 16'h0,    32'h0);
    chk("lit_pop2", 32'(result_data), 32'hAAAA);
    chk("lit_pop_sp", 32'(sp), 32'h3FF);

    // store/load with address aliasing
    cyc(0, 1, STD, 16'h0010, 16'h1234, 32'h0);
    cyc(0, 1, LDD, 16'hFC10, 16'h0,    32'h0);
    chk("lit_ldd", {15'h0, result_valid, result_data}, {15'h0, 1'b1, 16'h1234});
    cyc(0, 1, NOP, 16'h0, 16'h0, 32'h0);

    // call/return frame
    cyc(0, 1, CALL, 16'h0, 16'h0, 32'hDEADBEEF);
    cyc(0, 1, CALL, 16'h0, 16'h0, 32'hDEADBEEF);
    chk("lit_call_sp", 32'(sp), 32'h3FD);
    chk("lit_call_hi", 32'(dmem[10'h3FF]), 32'hDEAD);
    chk("lit_call_lo", 32'(dmem[10'h3FE]), 32'hBEEF);
    cyc(0, 1, RET, 16'h0, 16'h0, 32'h0);
    cyc(0, 1, RET, 16'h0, 16'h0, 32'h0);
    chk("lit_ret_pc", pc_out, 32'hDEADBEEF);
    chk("lit_ret_sp", 32'(sp), 32'h3FF);
    cyc(0, 1, NOP, 16'h0, 16'h0, 32'h0);

    // SP wrap both directions
    cyc(0, 1, POP, 16'h0, 16'h0, 32'h0);
    chk("lit_wrap_pop_sp", 32'(sp), 32'h000);
    chk("lit_wrap_pop_rd", 32'(result_data), 32'(init_val(0)));
    cyc(0, 1, PUSH, 16'h0, 16'h0F0F, 32'h0);
    chk("lit_wrap_push_sp", 32'(sp), 32'h3FF);
    chk("lit_wrap_push_mem", 32'(dmem[0]), 32'h0F0F);

    // CALL straddling the wrap point, then back-to-back push/pop
    cyc(0, 1, POP,  16'h0, 16'h0, 32'h0);
    cyc(0, 1, CALL, 16'h0, 16'h0, 32'hCAFE0123);
    cyc(0, 1, CALL, 16'h0, 16'h0, 32'hCAFE0123);
    chk("lit_wrapcall_sp", 32'(sp), 32'h3FE);
    cyc(0, 1, RET,  16'h0, 16'h0, 32'h0);
    cyc(0, 1, RET,  16'h0, 16'h0, 32'h0);
    cyc(0, 1, PUSH, 16'h0, 16'h7777, 32'h0);
    cyc(0, 1, POP,  16'h0, 16'h0, 32'h0);
    chk("lit_b2b_pop", 32'(result_data), 32'h7777);

    // reset during the second half of a CALL
    cyc(1, 0, NOP, 16'h0, 16'h0, 32'h0);
    cyc(0, 1, CALL, 16'h0, 16'h0, 32'h12345678);
    cyc(1, 1, CALL, 16'h0, 16'h0, 32'h12345678);
    chk("lit_rstcall_sp", 32'(sp), 32'h3FF);
    chk("lit_rstcall_half", 32'(dmem[10'h3FF]), 32'h1234);
    cyc(0, 0, NOP, 16'h0, 16'h0, 32'h0);
    chk("lit_rstcall_pv", 32'(pc_out_valid), 32'h0);

    // reset during the second half of a RET
    cyc(0, 1, RET, 16'h0, 16'h0, 32'h0);
    cyc(1, 1, RET, 16'h0, 16'h0, 32'h0);
    cyc(0, 0, NOP, 16'h0, 16'h0, 32'h0);

    // idle and illegal ops
    cyc(0, 1, BAD,  16'h0010, 16'hFFFF, 32'hFFFFFFFF);
    cyc(0, 0, PUSH, 16'h0010, 16'hFFFF, 32'h0);
    cyc(0, 0, CALL, 16'h0010, 16'hFFFF, 32'h0);
    cyc(0, 0, POP,  16'h0, 16'h0, 32'h0);
    chk("lit_idle_sp", 32'(sp), 32'h3FF);
    cyc(0, 1, NOP, 16'h0, 16'h0, 32'h0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
